// File: rtl/rf_access_arbiter.sv
// Arbitrates the single-port register file between decode reads and writeback writes.
// Optional write-before-read response bypass is enabled with RF_ARB_BYPASS_EN.
`ifndef RF_NOP
`define RF_NOP   2'd0
`endif
`ifndef RF_READ
`define RF_READ  2'd1
`endif
`ifndef RF_WRITE
`define RF_WRITE 2'd2
`endif

module rf_access_arbiter #(
  parameter int unsigned LEN           = 32,
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_in,
  input  logic           rd_req_valid,
  output logic           rd_req_ready,
  input  logic [4:0]     rd_rs1,
  input  logic [4:0]     rd_rs2,
  output logic           rsp_valid,
  output logic [LEN-1:0] rsp_rs1_data,
  output logic [LEN-1:0] rsp_rs2_data,
  input  logic           wb_valid,
  output logic           wb_ready,
  input  logic [4:0]     wb_rd,
  input  logic [LEN-1:0] wb_data,
  output logic [1:0]     rf_signal,
  output logic [4:0]     rf_rs1,
  output logic [4:0]     rf_rs2,
  output logic [4:0]     rf_rd,
  output logic [LEN-1:0] rf_data,
  input  logic [LEN-1:0] rf_rs1_data,
  input  logic [LEN-1:0] rf_rs2_data
);

  localparam logic [3:0] MAX_S = 4'(MAX_WR_STREAK);

  logic           rsp_pending;
  logic [3:0]     streak;
  logic [4:0]     cap_rs1, cap_rs2;
  logic [4:0]     rd_q;
  logic [LEN-1:0] data_q;

  logic active, real_wr, zero_wr, grant_wr, grant_rd;

  assign active   = rst & rdy_in;
  assign real_wr  = wb_valid & (wb_rd != 5'd0);
  assign zero_wr  = wb_valid & (wb_rd == 5'd0);
  assign grant_wr = active & real_wr & (~rd_req_valid | (streak < MAX_S));
  assign grant_rd = active & rd_req_valid & ~grant_wr;

  assign rd_req_ready = grant_rd;
  assign wb_ready     = grant_wr | (active & zero_wr);
  assign rsp_valid    = rsp_pending & rdy_in & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pending <= 1'b0;
      streak      <= '0;
      cap_rs1     <= '0;
      cap_rs2     <= '0;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      if (grant_rd) begin
        rsp_pending <= 1'b1;
        cap_rs1     <= rd_rs1;
        cap_rs2     <= rd_rs2;
      end else if (rsp_valid) begin
        rsp_pending <= 1'b0;
      end
      // A write granted while a read waits can only happen below MAX_S, so no overflow.
      if (!rd_req_valid || grant_rd)
        streak <= '0;
      else if (grant_wr)
        streak <= streak + 4'd1;
      if (grant_wr) begin
        rd_q   <= wb_rd;
        data_q <= wb_data;
      end
    end
  end

  // Index/data outputs keep their last driven values while the port is idle.
  always_comb begin
    rf_signal = `RF_NOP;
    rf_rs1    = cap_rs1;
    rf_rs2    = cap_rs2;
    rf_rd     = rd_q;
    rf_data   = data_q;
    if (grant_wr) begin
      rf_signal = `RF_WRITE;
      rf_rd     = wb_rd;
      rf_data   = wb_data;
    end else if (grant_rd) begin
      rf_signal = `RF_READ;
      rf_rs1    = rd_rs1;
      rf_rs2    = rd_rs2;
    end
  end

  always_comb begin
    rsp_rs1_data = (cap_rs1 == 5'd0) ? '0 : rf_rs1_data;
    rsp_rs2_data = (cap_rs2 == 5'd0) ? '0 : rf_rs2_data;
`ifdef RF_ARB_BYPASS_EN
    if (rsp_pending && grant_wr && (wb_rd == cap_rs1)) rsp_rs1_data = wb_data;
    if (rsp_pending && grant_wr && (wb_rd == cap_rs2)) rsp_rs2_data = wb_data;
`endif
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Table-driven check of rf_access_arbiter against a behavioural register file.
`ifndef RF_NOP
`define RF_NOP   2'd0
`endif
`ifndef RF_READ
`define RF_READ  2'd1
`endif
`ifndef RF_WRITE
`define RF_WRITE 2'd2
`endif

module tb_rf_access_arbiter;
  localparam int LEN = 32;
  localparam logic [1:0] N = `RF_NOP, R = `RF_READ, W = `RF_WRITE;
  localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004, A5 = 32'hA000_0005,
                          A6 = 32'hA000_0006, A7 = 32'hA000_0007, A8 = 32'hA000_0008,
                          A9 = 32'hA000_0009, B3 = 32'hB000_0003, C4 = 32'hC000_0004,
                          DB = 32'hDEAD_BEEF, D0 = 32'hD000_0000;
`ifdef RF_ARB_BYPASS_EN
  localparam logic [31:0] BYP = 32'h55;
`else
  localparam logic [31:0] BYP = 32'h1;
`endif

  logic clk = 0, rst = 0, rdy_in = 0;
  logic rd_req_valid = 0, rd_req_ready, rsp_valid, wb_valid = 0, wb_ready;
  logic [4:0] rd_rs1 = 0, rd_rs2 = 0, wb_rd = 0, rf_rs1, rf_rs2, rf_rd;
  logic [LEN-1:0] wb_data = 0, rsp_rs1_data, rsp_rs2_data, rf_data, rf_rs1_data, rf_rs2_data;
  logic [1:0] rf_signal;

  always #5 clk = ~clk;

  rf_access_arbiter #(.LEN(LEN), .MAX_WR_STREAK(4)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .rsp_valid(rsp_valid), .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_signal(rf_signal), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_data(rf_data), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data));

  // Register file with registered read outputs; x0 holds a junk value so forcing is visible.
  logic [31:0] regs [32];
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 | 32'(i);
    regs[0] = 32'hBAD0_0000;
    regs[7] = 32'h0;
    rf_rs1_data = '0;
    rf_rs2_data = '0;
  end
  always @(posedge clk) begin
    if (rst) begin
      if (rf_signal == `RF_WRITE) regs[rf_rd] <= rf_data;
      if (rf_signal == `RF_READ) begin
        rf_rs1_data <= regs[rf_rs1];
        rf_rs2_data <= regs[rf_rs2];
      end
    end
  end

  typedef struct {
    logic rdy, rv; logic [4:0] rs1, rs2; logic wv; logic [4:0] wrd; logic [31:0] wd;
    logic err, ewr; logic [1:0] esig; logic erv; logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs [35];
  int passed = 0, total = 0;

  function automatic vec_t mk(logic rdy, logic rv, logic [4:0] rs1, logic [4:0] rs2,
                              logic wv, logic [4:0] wrd, logic [31:0] wd,
                              logic err, logic ewr, logic [1:0] esig, logic erv,
                              logic [31:0] e1, logic [31:0] e2);
    vec_t t;
    t.rdy = rdy; t.rv = rv; t.rs1 = rs1; t.rs2 = rs2; t.wv = wv; t.wrd = wrd; t.wd = wd;
    t.err = err; t.ewr = ewr; t.esig = esig; t.erv = erv; t.e1 = e1; t.e2 = e2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    rdy_in = t.rdy; rd_req_valid = t.rv; rd_rs1 = t.rs1; rd_rs2 = t.rs2;
    wb_valid = t.wv; wb_rd = t.wrd; wb_data = t.wd;
  endtask

  task automatic apply(input int idx, input vec_t t);
    @(posedge clk); #1;
    drive(t);
    @(negedge clk);
    chk($sformatf("v%0d rd_req_ready", idx), 32'(rd_req_ready), 32'(t.err));
    chk($sformatf("v%0d wb_ready", idx), 32'(wb_ready), 32'(t.ewr));
    chk($sformatf("v%0d rf_signal", idx), 32'(rf_signal), 32'(t.esig));
    chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'(t.erv));
    if (t.erv) begin
      chk($sformatf("v%0d rsp_rs1_data", idx), rsp_rs1_data, t.e1);
      chk($sformatf("v%0d rsp_rs2_data", idx), rsp_rs2_data, t.e2);
    end
  endtask

  initial begin
    vecs[0]  = mk(1,1,1,2, 1,5,DB,        0,1,W, 0,0,0);
    vecs[1]  = mk(1,1,5,0, 0,0,0,         1,0,R, 0,0,0);
    vecs[2]  = mk(1,0,0,0, 0,0,0,         0,0,N, 1,DB,0);
    vecs[3]  = mk(1,1,3,4, 1,3,A3,        0,1,W, 0,0,0);
    vecs[4]  = mk(1,1,3,4, 1,4,A4,        0,1,W, 0,0,0);
    vecs[5]  = mk(1,1,3,4, 1,5,A5,        0,1,W, 0,0,0);
    vecs[6]  = mk(1,1,3,4, 1,6,A6,        0,1,W, 0,0,0);
    vecs[7]  = mk(1,1,3,4, 1,7,A7,        1,0,R, 0,0,0);
    vecs[8]  = mk(1,1,7,9, 1,7,A7,        0,1,W, 1,A3,A4);
    vecs[9]  = mk(1,1,7,9, 1,8,A8,        0,1,W, 0,0,0);
    vecs[10] = mk(1,1,7,9, 1,9,A9,        0,1,W, 0,0,0);
    vecs[11] = mk(1,1,7,9, 1,3,B3,        0,1,W, 0,0,0);
    vecs[12] = mk(1,1,7,9, 1,4,C4,        1,0,R, 0,0,0);
    vecs[13] = mk(1,1,0,3, 1,4,C4,        0,1,W, 1,A7,A9);
    vecs[14] = mk(1,1,0,3, 1,0,32'hFFFF_FFFF, 1,1,R, 0,0,0);
    vecs[15] = mk(1,0,0,0, 0,0,0,         0,0,N, 1,0,B3);
    vecs[16] = mk(1,1,4,5, 0,0,0,         1,0,R, 0,0,0);
    vecs[17] = mk(1,1,6,8, 0,0,0,         1,0,R, 1,C4,A5);
    vecs[18] = mk(1,0,0,0, 0,0,0,         0,0,N, 1,A6,A8);
    vecs[19] = mk(1,1,9,3, 0,0,0,         1,0,R, 0,0,0);
    vecs[20] = mk(0,1,1,2, 1,10,D0,       0,0,N, 0,0,0);
    vecs[21] = mk(0,1,1,2, 1,10,D0,       0,0,N, 0,0,0);
    vecs[22] = mk(0,1,1,2, 1,10,D0,       0,0,N, 0,0,0);
    vecs[23] = mk(1,0,0,0, 0,0,0,         0,0,N, 1,A9,B3);
    vecs[24] = mk(1,0,0,0, 1,7,32'h1,     0,1,W, 0,0,0);
    vecs[25] = mk(1,1,7,7, 0,0,0,         1,0,R, 0,0,0);
    vecs[26] = mk(1,0,0,0, 1,7,32'h55,    0,1,W, 1,BYP,BYP);
    vecs[27] = mk(1,1,1,2, 1,10,D0,       0,1,W, 0,0,0);
    vecs[28] = mk(1,1,1,2, 1,10,D0,       0,1,W, 0,0,0);
    vecs[29] = mk(1,0,1,2, 1,10,D0,       0,1,W, 0,0,0);
    for (int i = 30; i < 34; i++) vecs[i] = mk(1,1,1,2, 1,10,D0, 0,1,W, 0,0,0);
    vecs[34] = mk(1,1,1,2, 1,10,D0,       1,0,R, 0,0,0);

    // Reset with every request asserted: all grants suppressed.
    rst = 0; rdy_in = 1; rd_req_valid = 1; wb_valid = 1; wb_rd = 5'd5; rd_rs1 = 5'd1;
    repeat (2) @(negedge clk);
    chk("reset rf_signal", 32'(rf_signal), 32'(N));
    chk("reset rd_req_ready", 32'(rd_req_ready), 0);
    chk("reset wb_ready", 32'(wb_ready), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    rd_req_valid = 0; wb_valid = 0;
    #1 rst = 1;

    for (int i = 0; i < 35; i++) apply(i, vecs[i]);

    // Reset while the last read's response is still pending drops that response.
    @(posedge clk); #1;
    rd_req_valid = 0; wb_valid = 0; rdy_in = 1;
    #2 rst = 0;
    @(negedge clk);
    chk("midreset rsp_valid", 32'(rsp_valid), 0);
    chk("midreset rf_signal", 32'(rf_signal), 32'(N));
    #1 rst = 1;
    apply(35, mk(1,0,0,0, 0,0,0, 0,0,N, 0,0,0));
    apply(36, mk(1,1,5,6, 0,0,0, 1,0,R, 0,0,0));
    apply(37, mk(1,0,0,0, 0,0,0, 0,0,N, 1,A5,A6));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
